// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

    // Bits handled per serial step
    localparam int unsigned NibW = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_add4.sv
// 4-bit combinational adder slice; also exposes the carry into bit 3 so the
// caller can form two's-complement overflow on the MSB nibble.
module nibble_add4
    import nibble_serial_adder_pkg::*;
(
    input  logic [NibW-1:0] a_i,
    input  logic [NibW-1:0] b_i,
    input  logic            c_i,
    output logic [NibW-1:0] s_o,
    output logic            c_o,
    output logic            c3_o
);

    logic [3:0] low;

    // Bits 2..0 first, then bit 3 so its carry-in is visible
    always_comb begin
        low    = {1'b0, a_i[2:0]} + {1'b0, b_i[2:0]} + {3'b000, c_i};
        c3_o   = low[3];
        s_o    = {a_i[3] ^ b_i[3] ^ low[3], low[2:0]};
        c_o    = (a_i[3] & b_i[3]) | (low[3] & (a_i[3] ^ b_i[3]));
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder: one nibble per clock, LSB first, through a single shared
// 4-bit slice. Fixed latency of NIB RUN cycles plus one DONE cycle.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NIB  = WIDTH / NibW;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

    logic [NibW-1:0]   nib_a, nib_b, nib_s;
    logic              nib_c, nib_c3, last;

    // Operand nibble select, shared slice
    assign nib_a = a_q[idx_q*NibW +: NibW];
    assign nib_b = b_q[idx_q*NibW +: NibW];
    assign last  = (idx_q == IdxW'(NIB - 1));

    nibble_add4 u_add4 (
        .a_i  (nib_a),
        .b_i  (nib_b),
        .c_i  (carry_q),
        .s_o  (nib_s),
        .c_o  (nib_c),
        .c3_o (nib_c3)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last)  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    // Datapath next-state: capture on start, one nibble per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == StIdle && start) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
        end else if (state_q == StRun) begin
            sum_d[idx_q*NibW +: NibW] = nib_s;
            carry_d = nib_c;
            if (last) begin
                idx_d  = '0;
                cout_d = nib_c;
                ovf_d  = nib_c ^ nib_c3;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks for nibble_serial_adder at WIDTH=16.
module tb_nibble_serial_adder;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             cin = 1'b0;
    logic             busy, done, cout, ovf;
    logic [WIDTH-1:0] sum;

    int total = 0;
    int bad   = 0;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count negedges until done; n = number of edges since the call
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 40);
    endtask

    // One full operation with directed operands and expected results
    task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] es, input logic ec, input logic eo);
        int n;
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~va; b = ~vb; cin = ~vc;   // must not disturb the operation in flight
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_done(n);
        chk({tag, "_lat"}, 64'(n), 64'(NIB));
        chk({tag, "_res"}, {46'd0, ovf, cout, sum}, {46'd0, eo, ec, es});
        @(negedge clk);
        chk({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    endtask

    int n, dones;
    logic [16:0] e;
    logic        eo;

    initial begin
        // Reset state
        #12;
        chk("rst_out", {45'd0, busy, done, ovf, cout, sum}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("add1234", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        do_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("ovfpos",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        do_op("ovfneg",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Start while busy and during DONE is ignored
        @(negedge clk);
        a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'h0F0F; start = 1'b1;       // sampled at edge 2 of the operation
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                dones++;
                chk("busy_res", {47'd0, ovf, cout, sum}, 64'h5555);
                start = 1'b1;              // asserted only through the DONE cycle
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_dones", 64'(dones), 64'd1);
        chk("busy_idle", 64'(busy), 64'd0);

        // Asynchronous reset mid-RUN aborts without a done pulse
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("arst_out", {45'd0, busy, done, ovf, cout, sum}, 64'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("arst_nodone", 64'(dones), 64'd0);
        do_op("post_rst", 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0);

        // Back-to-back random operations with start held high
        @(negedge clk);
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        start = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            e  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            eo = (a[15] == b[15]) && (e[15] != a[15]);
            wait_done(n);
            chk("rnd_res", {46'd0, ovf, cout, sum}, {46'd0, eo, e});
            if (i > 0) chk("rnd_gap", 64'(n), 64'(NIB + 2));
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        end
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
